// File: rtl/ball_ctl.sv
// ball_ctl -- frame-rate ball motion controller for the pong game.
//
// Holds the ball centred while idle or waiting to serve. Once serving ends it
// moves the ball once per frame_tick. It bounces the ball off the walls and the
// paddles, and detects misses. Misses and paddle hits are reported as
// one-cycle pulses.
//
// Optional feature macro: BALL_SPEEDUP_EN
//   defined   : each paddle hit raises the horizontal speed by one, up to
//               SPEED_MAX; every serve restarts at SPEED_INIT.
//   undefined : horizontal speed is fixed at SPEED_INIT (no speed register).
//
// Ports:
//   clk         in   1   pixel clock
//   rst         in   1   synchronous active-high reset
//   frame_tick  in   1   one-cycle pulse per frame (vblank start)
//   game_state  in   2   00 menu_start, 01 play, 10 game_over
//   pad_l_y     in  10   left paddle top y
//   pad_r_y     in  10   right paddle top y
//   ball_x      out 11   ball top-left x (registered)
//   ball_y      out 10   ball top-left y (registered)
//   hit         out  1   one-cycle pulse on a paddle bounce
//   score_l     out  1   one-cycle pulse, ball left the field on the right
//   score_r     out  1   one-cycle pulse, ball left the field on the left

module ball_ctl #(
    parameter int PAD_X_L      = 20,
    parameter int PAD_X_R      = 989,
    parameter int PAD_WIDTH    = 15,
    parameter int SPEED_INIT   = 4,
    parameter int SPEED_MAX    = 12,
    parameter int DY           = 3,
    parameter int SERVE_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [1:0]  game_state,
    input  logic [9:0]  pad_l_y,
    input  logic [9:0]  pad_r_y,
    output logic [10:0] ball_x,
    output logic [9:0]  ball_y,
    output logic        hit,
    output logic        score_l,
    output logic        score_r
);

    // Screen geometry shared with the VGA stages.
    localparam int HOR_PIXELS = 32'sd1024;
    localparam int VER_PIXELS = 32'sd768;
    localparam int BALLSIZE   = 32'sd15;
    localparam int PAD_HEIGHT = 32'sd145;

    localparam logic [1:0] GS_PLAY = 2'b01;

    localparam int CNT_W = (SERVE_FRAMES > 32'sd1) ? $clog2(SERVE_FRAMES + 32'sd1) : 32'sd1;
    localparam int SPD_W = $clog2(SPEED_MAX + 32'sd1);

    localparam logic [10:0] CX      = 11'((HOR_PIXELS - BALLSIZE) / 32'sd2);
    localparam logic [9:0]  CY      = 10'((VER_PIXELS - BALLSIZE) / 32'sd2);
    localparam logic [9:0]  YMAX    = 10'(VER_PIXELS - BALLSIZE);
    localparam logic [10:0] L_CLAMP = 11'(PAD_X_L + PAD_WIDTH);
    localparam logic [10:0] R_CLAMP = 11'(PAD_X_R - BALLSIZE);

    // 12-bit signed copies for the next-position arithmetic.
    localparam logic signed [11:0] XMAX_S    = 12'(HOR_PIXELS - BALLSIZE);
    localparam logic signed [11:0] YMAX_S    = 12'(VER_PIXELS - BALLSIZE);
    localparam logic signed [11:0] BALL_S    = 12'(BALLSIZE);
    localparam logic signed [11:0] PADH_S    = 12'(PAD_HEIGHT);
    localparam logic signed [11:0] DY_S      = 12'(DY);
    localparam logic signed [11:0] PAD_XL_S  = 12'(PAD_X_L);
    localparam logic signed [11:0] L_EDGE_S  = 12'(PAD_X_L + PAD_WIDTH);
    localparam logic signed [11:0] PAD_XR_S  = 12'(PAD_X_R);
    localparam logic signed [11:0] R_OUTER_S = 12'(PAD_X_R + PAD_WIDTH);
    localparam logic signed [11:0] ZERO_S    = 12'sd0;

    localparam logic [SPD_W-1:0] SPD_INIT  = SPD_W'(SPEED_INIT);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(SERVE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SERVE  = 2'b01,
        ST_MOVE   = 2'b10,
        ST_SCORED = 2'b11
    } state_t;

    state_t             state_r, next_state_s;
    logic [10:0]        x_r, x_nxt_s;
    logic [9:0]         y_r, y_nxt_s;
    logic               dx_right_r, dx_right_nxt_s;
    logic               dy_down_r, dy_down_nxt_s;
    logic               serve_dir_r, serve_dir_nxt_s;
    logic [CNT_W-1:0]   serve_cnt_r, serve_cnt_nxt_s;
    logic               hit_r, hit_nxt_s;
    logic               sc_l_r, sc_l_nxt_s;
    logic               sc_r_r, sc_r_nxt_s;
    logic [SPD_W-1:0]   speed_s;

    logic signed [11:0] x_ext_s, y_ext_s, spd_ext_s;
    logic signed [11:0] pad_l_ext_s, pad_r_ext_s;
    logic signed [11:0] nx_s, ny_s;
    logic               ovl_l_s, ovl_r_s;
    logic               left_hit_s, right_hit_s;

`ifdef BALL_SPEEDUP_EN
    localparam logic [SPD_W-1:0] SPD_MAX = SPD_W'(SPEED_MAX);
    localparam logic [SPD_W-1:0] SPD_ONE = SPD_W'(1);

    logic [SPD_W-1:0] speed_r, speed_nxt_s;

    assign speed_s = speed_r;
`else
    assign speed_s = SPD_INIT;
`endif

    // Widen the current position, speed and paddles to 12-bit signed.
    assign x_ext_s     = $signed({1'b0, x_r});
    assign y_ext_s     = $signed({2'b00, y_r});
    assign spd_ext_s   = $signed({{(12 - SPD_W){1'b0}}, speed_s});
    assign pad_l_ext_s = $signed({2'b00, pad_l_y});
    assign pad_r_ext_s = $signed({2'b00, pad_r_y});

    // Candidate position for this frame, before any bounce or clamp.
    assign nx_s = dx_right_r ? (x_ext_s + spd_ext_s) : (x_ext_s - spd_ext_s);
    assign ny_s = dy_down_r  ? (y_ext_s + DY_S)      : (y_ext_s - DY_S);

    // Vertical overlap between the ball's current rows and each paddle.
    assign ovl_l_s = ((y_ext_s + BALL_S) > pad_l_ext_s) && (y_ext_s < (pad_l_ext_s + PADH_S));
    assign ovl_r_s = ((y_ext_s + BALL_S) > pad_r_ext_s) && (y_ext_s < (pad_r_ext_s + PADH_S));

    // A paddle only catches the ball while the ball is still in front of the
    // paddle's outer edge; once past it the ball is already lost.
    assign left_hit_s  = !dx_right_r && (nx_s <= L_EDGE_S) && (x_ext_s > PAD_XL_S) && ovl_l_s;
    assign right_hit_s = dx_right_r && ((nx_s + BALL_S) >= PAD_XR_S)
                         && ((x_ext_s + BALL_S) < R_OUTER_S) && ovl_r_s;

    // Next-state, next-position and event pulse decode.
    always_comb begin
        next_state_s    = state_r;
        x_nxt_s         = x_r;
        y_nxt_s         = y_r;
        dx_right_nxt_s  = dx_right_r;
        dy_down_nxt_s   = dy_down_r;
        serve_dir_nxt_s = serve_dir_r;
        serve_cnt_nxt_s = serve_cnt_r;
        hit_nxt_s       = 1'b0;
        sc_l_nxt_s      = 1'b0;
        sc_r_nxt_s      = 1'b0;
`ifdef BALL_SPEEDUP_EN
        speed_nxt_s     = speed_r;
`endif

        if (game_state != GS_PLAY) begin
            // Leaving play always wins, even over a frame tick.
            next_state_s = ST_IDLE;
            x_nxt_s      = CX;
            y_nxt_s      = CY;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    next_state_s    = ST_SERVE;
                    serve_cnt_nxt_s = CNT_LOAD;
                    x_nxt_s         = CX;
                    y_nxt_s         = CY;
                end

                ST_SERVE: begin
                    x_nxt_s = CX;
                    y_nxt_s = CY;
                    if (frame_tick) begin
                        if (serve_cnt_r <= CNT_ONE) begin
                            // Count reaches zero: launch. The ball first moves
                            // on the next tick.
                            serve_cnt_nxt_s = CNT_ZERO;
                            next_state_s    = ST_MOVE;
                            dx_right_nxt_s  = serve_dir_r;
                            dy_down_nxt_s   = 1'b1;
`ifdef BALL_SPEEDUP_EN
                            speed_nxt_s     = SPD_INIT;
`endif
                        end else begin
                            serve_cnt_nxt_s = serve_cnt_r - CNT_ONE;
                        end
                    end else begin
                        serve_cnt_nxt_s = serve_cnt_r;
                    end
                end

                ST_MOVE: begin
                    if (frame_tick) begin
                        if (!dx_right_r && (nx_s <= ZERO_S)) begin
                            sc_r_nxt_s   = 1'b1;
                            next_state_s = ST_SCORED;
                        end else if (dx_right_r && (nx_s >= XMAX_S)) begin
                            sc_l_nxt_s   = 1'b1;
                            next_state_s = ST_SCORED;
                        end else begin
                            if (left_hit_s) begin
                                x_nxt_s        = L_CLAMP;
                                dx_right_nxt_s = 1'b1;
                                hit_nxt_s      = 1'b1;
                            end else if (right_hit_s) begin
                                x_nxt_s        = R_CLAMP;
                                dx_right_nxt_s = 1'b0;
                                hit_nxt_s      = 1'b1;
                            end else begin
                                x_nxt_s = nx_s[10:0];
                            end
`ifdef BALL_SPEEDUP_EN
                            if ((left_hit_s || right_hit_s) && (speed_r < SPD_MAX)) begin
                                speed_nxt_s = speed_r + SPD_ONE;
                            end else begin
                                speed_nxt_s = speed_r;
                            end
`endif
                            // Walls act in the same frame as any paddle bounce.
                            if (ny_s <= ZERO_S) begin
                                y_nxt_s       = 10'd0;
                                dy_down_nxt_s = 1'b1;
                            end else if (ny_s >= YMAX_S) begin
                                y_nxt_s       = YMAX;
                                dy_down_nxt_s = 1'b0;
                            end else begin
                                y_nxt_s = ny_s[9:0];
                            end
                        end
                    end else begin
                        next_state_s = ST_MOVE;
                    end
                end

                ST_SCORED: begin
                    // Lasts exactly one clock; any frame tick here is ignored.
                    next_state_s    = ST_SERVE;
                    serve_cnt_nxt_s = CNT_LOAD;
                    serve_dir_nxt_s = !serve_dir_r;
                    x_nxt_s         = CX;
                    y_nxt_s         = CY;
                end

                default: begin
                    next_state_s = ST_IDLE;
                    x_nxt_s      = CX;
                    y_nxt_s      = CY;
                end
            endcase
        end
    end

    // State, position, direction and output pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            x_r         <= CX;
            y_r         <= CY;
            dx_right_r  <= 1'b1;
            dy_down_r   <= 1'b1;
            serve_dir_r <= 1'b1;
            serve_cnt_r <= CNT_ZERO;
            hit_r       <= 1'b0;
            sc_l_r      <= 1'b0;
            sc_r_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            x_r         <= x_nxt_s;
            y_r         <= y_nxt_s;
            dx_right_r  <= dx_right_nxt_s;
            dy_down_r   <= dy_down_nxt_s;
            serve_dir_r <= serve_dir_nxt_s;
            serve_cnt_r <= serve_cnt_nxt_s;
            hit_r       <= hit_nxt_s;
            sc_l_r      <= sc_l_nxt_s;
            sc_r_r      <= sc_r_nxt_s;
        end
    end

`ifdef BALL_SPEEDUP_EN
    // Horizontal speed register, grows on paddle hits.
    always_ff @(posedge clk) begin
        if (rst) begin
            speed_r <= SPD_INIT;
        end else begin
            speed_r <= speed_nxt_s;
        end
    end
`endif

    assign ball_x  = x_r;
    assign ball_y  = y_r;
    assign hit     = hit_r;
    assign score_l = sc_l_r;
    assign score_r = sc_r_r;

endmodule

// File: tb/tb_ball_ctl.sv
// Scoreboard bench for ball_ctl. The stimulus process drives the inputs clock
// by clock and steps a small behavioural model of the ball. For every frame
// tick it queues the outputs expected in the following cycle. A monitor pops
// and compares on each update cycle, and checks that no pulse appears
// elsewhere. Landmark values (centre, first serve step, paddle clamps) are
// also checked against hand-computed constants.

module tb_ball_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic [1:0]  game_state;
    logic [9:0]  pad_l_y;
    logic [9:0]  pad_r_y;
    logic [10:0] ball_x;
    logic [9:0]  ball_y;
    logic        hit;
    logic        score_l;
    logic        score_r;

    ball_ctl dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .game_state (game_state),
        .pad_l_y    (pad_l_y),
        .pad_r_y    (pad_r_y),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .hit        (hit),
        .score_l    (score_l),
        .score_r    (score_r)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic        h;
        logic        sl;
        logic        sr;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state
    localparam int M_IDLE = 0, M_SERVE = 1, M_MOVE = 2, M_SCORED = 3;
    int m_st, m_x, m_y, m_spd, m_cnt;
    bit m_right, m_down, m_dir_right;
    bit e_hit, e_sl, e_sr;

    task automatic model_edge(input bit tk);
        int nx;
        int ny;
        int pl;
        int pr;
        e_hit = 1'b0; e_sl = 1'b0; e_sr = 1'b0;
        pl = int'(pad_l_y);
        pr = int'(pad_r_y);
        if (rst) begin
            m_st = M_IDLE; m_x = 504; m_y = 376; m_dir_right = 1'b1;
            m_right = 1'b1; m_down = 1'b1; m_spd = 4; m_cnt = 0;
        end else if (game_state != 2'b01) begin
            m_st = M_IDLE; m_x = 504; m_y = 376;
        end else begin
            case (m_st)
                M_IDLE: begin m_st = M_SERVE; m_cnt = 60; end
                M_SERVE: begin
                    if (tk) begin
                        if (m_cnt <= 1) begin
                            m_cnt = 0; m_st = M_MOVE; m_right = m_dir_right;
                            m_down = 1'b1; m_spd = 4;
                        end else begin
                            m_cnt = m_cnt - 1;
                        end
                    end
                end
                M_MOVE: begin
                    if (tk) begin
                        nx = m_right ? m_x + m_spd : m_x - m_spd;
                        ny = m_down ? m_y + 3 : m_y - 3;
                        if (!m_right && nx <= 0) begin
                            e_sr = 1'b1; m_st = M_SCORED;
                        end else if (m_right && nx >= 1009) begin
                            e_sl = 1'b1; m_st = M_SCORED;
                        end else begin
                            if (!m_right && nx <= 35 && m_x > 20 && m_y + 15 > pl && m_y < pl + 145) begin
                                nx = 35; m_right = 1'b1; e_hit = 1'b1;
                            end else if (m_right && nx + 15 >= 989 && m_x + 15 < 1004
                                         && m_y + 15 > pr && m_y < pr + 145) begin
                                nx = 974; m_right = 1'b0; e_hit = 1'b1;
                            end
`ifdef BALL_SPEEDUP_EN
                            if (e_hit && m_spd < 12) m_spd = m_spd + 1;
`endif
                            if (ny <= 0) begin
                                ny = 0; m_down = 1'b1;
                            end else if (ny >= 753) begin
                                ny = 753; m_down = 1'b0;
                            end
                            m_x = nx; m_y = ny;
                        end
                    end
                end
                M_SCORED: begin
                    m_x = 504; m_y = 376; m_dir_right = !m_dir_right;
                    m_st = M_SERVE; m_cnt = 60;
                end
                default: m_st = M_IDLE;
            endcase
        end
    endtask

    // One clock: drive inputs, step the model at the edge, queue expectation.
    task automatic step(input logic tk);
        exp_t e;
        frame_tick = tk;
        @(posedge clk);
        model_edge(tk);
        if (tk) begin
            e.x  = m_x[10:0];
            e.y  = m_y[9:0];
            e.h  = e_hit;
            e.sl = e_sl;
            e.sr = e_sr;
            sb_q.push_back(e);
        end
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic tick_gap();
        step(1'b1);
        repeat (3) step(1'b0);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [9:0] track(input int y);
        return (y > 50) ? 10'(y - 50) : 10'd0;
    endfunction

    function automatic logic [9:0] away(input int y);
        return (y < 380) ? 10'd700 : 10'd0;
    endfunction

    // Monitor: compare on update cycles, require quiet pulses otherwise.
    logic tick_q = 1'b0;
    exp_t got_e;
    exp_t exp_e;
    always @(posedge clk) tick_q <= frame_tick;

    always @(negedge clk) begin
        got_e = {ball_x, ball_y, hit, score_l, score_r};
        n_vec++;
        if (tick_q) begin
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL update: output cycle with empty scoreboard, got x=%0d y=%0d", ball_x, ball_y);
            end else begin
                exp_e = sb_q.pop_front();
                if (got_e !== exp_e) begin
                    n_err++;
                    $display("FAIL update @%0t: got x=%0d y=%0d hit=%0b sl=%0b sr=%0b, expected x=%0d y=%0d hit=%0b sl=%0b sr=%0b",
                             $time, ball_x, ball_y, hit, score_l, score_r,
                             exp_e.x, exp_e.y, exp_e.h, exp_e.sl, exp_e.sr);
                end
            end
        end else if ({hit, score_l, score_r} !== 3'b000) begin
            n_err++;
            $display("FAIL quiet_pulses @%0t: got hit=%0b sl=%0b sr=%0b, expected all 0",
                     $time, hit, score_l, score_r);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst = 1'b1; frame_tick = 1'b0; game_state = 2'b00;
        pad_l_y = 10'd0; pad_r_y = 10'd0;
        repeat (3) step(1'b0);
        chk("reset_x", ball_x, 504);
        chk("reset_y", ball_y, 376);
        chk("reset_pulses", {hit, score_l, score_r}, 0);
        rst = 1'b0;

        // Menu: ball stays centred.
        repeat (100) tick_gap();
        chk("menu_x", ball_x, 504);
        chk("menu_y", ball_y, 376);

        // Play: 60 static ticks, the 61st moves the ball right and down.
        game_state = 2'b01;
        step(1'b0);
        repeat (60) tick_gap();
        chk("serve_static_x", ball_x, 504);
        chk("serve_static_y", ball_y, 376);
        step(1'b1);
        chk("first_move_x", ball_x, 508);
        chk("first_move_y", ball_y, 379);
        repeat (3) step(1'b0);

        // Both paddles follow the ball: right bounce, then left bounce.
        found = 1'b0;
        for (int i = 0; i < 1500 && !found; i++) begin
            pad_l_y = track(m_y);
            pad_r_y = track(m_y);
            step(1'b1);
            if (e_hit && m_x == 974) chk("right_clamp_x", ball_x, 974);
            if (e_hit && m_x == 35) begin
                found = 1'b1;
                chk("left_clamp_x", ball_x, 35);
                chk("left_hit_pulse", hit, 1);
            end
            repeat (3) step(1'b0);
        end
        chk("left_hit_seen", found, 1);

        // Left paddle out of the way: ball returns, then is missed on the left.
        found = 1'b0;
        for (int i = 0; i < 1500 && !found; i++) begin
            pad_l_y = away(m_y);
            pad_r_y = track(m_y);
            step(1'b1);
            if (m_y == 0) chk("wall_top_y", ball_y, 0);
            if (m_st == M_SCORED) begin
                found = 1'b1;
                chk("miss_score_r", score_r, 1);
                chk("miss_score_l", score_l, 0);
                chk("miss_hit", hit, 0);
                step(1'b1);   // tick during SCORED, must be ignored
                chk("scored_recentre_x", ball_x, 504);
                chk("scored_recentre_y", ball_y, 376);
            end
            repeat (3) step(1'b0);
        end
        chk("miss_seen", found, 1);

        // Next serve goes left after a full 60-tick wait.
        repeat (60) tick_gap();
        chk("serve2_static_x", ball_x, 504);
        step(1'b1);
        chk("serve2_left_x", ball_x, 500);
        chk("serve2_left_y", ball_y, 379);
        repeat (3) step(1'b0);
        repeat (5) tick_gap();

        // game_over together with a frame tick: recentre, no pulses.
        game_state = 2'b10;
        step(1'b1);
        chk("gameover_x", ball_x, 504);
        chk("gameover_y", ball_y, 376);
        chk("gameover_pulses", {hit, score_l, score_r}, 0);
        repeat (3) step(1'b0);

        // Back to play: serve direction still left.
        game_state = 2'b01;
        step(1'b0);
        repeat (61) tick_gap();
        chk("replay_left_x", ball_x, 500);
        repeat (3) tick_gap();

        // Reset mid-flight with a tick: reset values, serve direction right.
        rst = 1'b1;
        step(1'b1);
        chk("midrst_x", ball_x, 504);
        chk("midrst_y", ball_y, 376);
        rst = 1'b0;
        step(1'b0);
        repeat (60) tick_gap();
        step(1'b1);
        chk("post_rst_serve_x", ball_x, 508);
        chk("post_rst_serve_y", ball_y, 379);
        repeat (3) step(1'b0);

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
